sev_seg_capture: RTL and testbench
==================================

Name: sev_seg_capture

Overview:
- Receive-side monitor for the multiplexed 4-digit seven-segment bus: the segment lines plus the active-low digit enables.
- Watches that bus, decodes each segment pattern back to a 4-bit hex value, and assembles a full frame once all four digits have been captured.
- Used as an on-chip self-check of the display path and as the loopback checker in the display testbench.
- Outputs are registered and frame-aligned, with per-digit error flags.

Parameters:
- STABLE_CYCLES, 1: consecutive cycles a {segments, enable} value must hold before it is captured. Range 1..255.
- TIMEOUT, 1024: cycles without a capture before a partially assembled frame is discarded. Must be ≥ 4·STABLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- sev_seg_leds  in  8  segment lines, active-low. bit0=a … bit6=g, bit7=dp.
- led_enable  in  4  digit enables, active-low. 1110 = digit 1, 1101 = digit 2, 1011 = digit 3, 0111 = digit 4.
- num_1, num_2, num_3, num_4  out  4 each  decoded digit values of the last complete frame.
- dp  out  4  decimal-point state per digit, 1 = lit. bit0 = digit 1.
- digit_err  out  4  1 = the digit's segment pattern was not a legal hex glyph in the last frame.
- frame_valid  out  1  one-cycle pulse when num_x, dp and digit_err update.
- enable_err  out  1  one-cycle pulse on an illegal enable pattern.

Behaviour:
- Reset (reset=0, async): all outputs 0; internal shadow registers, capture mask, stability counter and timeout counter cleared.
- Input stage: sev_seg_leds and led_enable are registered once before any use.
- Stability counter:
  - Tracks how long the registered {seg, en} pair has held.
  - Restarts at 1 on any change.
  - A capture strobe fires exactly once per dwell, in the cycle the count reaches STABLE_CYCLES.
  - With STABLE_CYCLES=1, every sampled cycle is a capture candidate.
- Segment decode (active-low, bit7 ignored):
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9, 88→A, 83→b, C6→C, A1→d, 86→E, 8E→F.
  - Any other 7-bit pattern → value 0 with error bit 1.
  - dp = ~seg[7].
- Capture, on a strobe with a legal one-hot-low enable:
  - Write shadow value, error bit and dp for the indexed digit.
  - Set that digit's mask bit.
  - A repeat of an already-masked digit overwrites its shadow entry.
- Enable 1111 (blanked): no capture, no error; mask retained.
- Any other enable pattern: enable_err pulses the cycle after the strobe; mask cleared; shadow contents don't care.
- Frame complete: when the mask becomes 1111 (including the capture that completes it), on the next edge:
  - num_1..num_4, dp and digit_err load from shadow;
  - frame_valid = 1 for one cycle;
  - mask clears.
  - Outputs otherwise hold their last frame.
- Latency: if the completing digit is present at the pins before edge k, it is captured at edge k+STABLE_CYCLES and frame_valid is high after edge k+STABLE_CYCLES+1.
- Timeout counter:
  - Increments every cycle without a capture and saturates; resets to 0 on any capture.
  - On reaching TIMEOUT it clears the mask. Outputs and flags are unchanged.
- Simultaneous events: completing capture plus illegal enable cannot coincide, since there is one strobe per cycle. Timeout and capture in the same cycle → capture wins.
- Reset mid-frame: partial frame is lost; the first frame_valid after release requires four fresh captures.
- Scan order is free: any order that covers all four digits completes a frame.

Test Plan:
1. STABLE_CYCLES=1; drive per cycle (1110,F9),(1101,A4),(1011,B0),(0111,99) → exactly one frame_valid pulse two cycles after the last pair; num_1..4 = 1,2,3,4; digit_err=0000; dp=0000.
2. Same scan with digit 2 segments = FF and digit 3 = 30 → num_2=0, digit_err=0010, num_3=3, dp=0100.
3. Scan 1110, then 1100, then all four legal digits → enable_err pulses once; frame_valid fires only after the four post-error captures.
4. STABLE_CYCLES=3; each digit held 4 cycles, with a one-cycle glitch (1101,88) inside digit 1's dwell → glitch not captured; frame shows 1,2,3,4; one frame_valid.
5. Capture digits 1–3, stall at 1111 for TIMEOUT cycles, then send digit 4 only → no frame_valid; a new full scan then yields a frame.
6. Assert reset (0) after three captures; release; send only digit 4 → no frame_valid; outputs stay 0; a full scan then gives frame_valid.

Source files
------------

// File: rtl/sev_seg_capture_if.sv
// Seven-segment bus monitor interface: the scanned
// display bus in, the reassembled frame and flags out.
interface sev_seg_capture_if;
   logic [7:0] sev_seg_leds;
   logic [3:0] led_enable;
   logic [3:0] num_1;
   logic [3:0] num_2;
   logic [3:0] num_3;
   logic [3:0] num_4;
   logic [3:0] dp;
   logic [3:0] digit_err;
   logic       frame_valid;
   logic       enable_err;

   modport master (
      output sev_seg_leds,
      output led_enable,
      input  num_1,
      input  num_2,
      input  num_3,
      input  num_4,
      input  dp,
      input  digit_err,
      input  frame_valid,
      input  enable_err
   );

   modport slave (
      input  sev_seg_leds,
      input  led_enable,
      output num_1,
      output num_2,
      output num_3,
      output num_4,
      output dp,
      output digit_err,
      output frame_valid,
      output enable_err
   );
endinterface

// File: rtl/sev_seg_capture.sv
// Multiplexed 4-digit seven-segment bus monitor: debounces
// each dwell, decodes glyphs and emits complete frames.
module sev_seg_capture #(
   parameter int STABLE_CYCLES = 1,
   parameter int TIMEOUT       = 1024
) (
   input  logic              clk,
   input  logic              reset,
   sev_seg_capture_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    SC    = 8'(STABLE_CYCLES);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   logic [7:0]      seg_q, seg_last_q;
   logic [3:0]      en_q, en_last_q;
   logic [7:0]      cnt_q, cnt_d;
   logic [TW-1:0]   to_q, to_d;
   logic [3:0]      mask_q, mask_d;
   logic [3:0][3:0] shv_q, shv_d;
   logic [3:0]      shdp_q, shdp_d;
   logic [3:0]      sherr_q, sherr_d;
   logic [3:0][3:0] num_q;
   logic [3:0]      dp_q, derr_q;
   logic            fv_q, ee_q;

   logic       chg, strobe, legal, blank;
   logic       cap, eerr, tmo, frame;
   logic [1:0] idx;
   logic [3:0] val;
   logic       gerr;

   always_comb begin
      val  = 4'h0;
      gerr = 1'b0;
      unique case (seg_q[6:0])
         7'h40:   val = 4'h0;
         7'h79:   val = 4'h1;
         7'h24:   val = 4'h2;
         7'h30:   val = 4'h3;
         7'h19:   val = 4'h4;
         7'h12:   val = 4'h5;
         7'h02:   val = 4'h6;
         7'h78:   val = 4'h7;
         7'h00:   val = 4'h8;
         7'h10:   val = 4'h9;
         7'h08:   val = 4'hA;
         7'h03:   val = 4'hB;
         7'h46:   val = 4'hC;
         7'h21:   val = 4'hD;
         7'h06:   val = 4'hE;
         7'h0E:   val = 4'hF;
         default: gerr = 1'b1;
      endcase
   end

   always_comb begin
      legal = 1'b1;
      idx   = 2'd0;
      case (en_q)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      chg = {seg_q, en_q} != {seg_last_q, en_last_q};
      if (chg)
         cnt_d = 8'd1;
      else if (cnt_q == SC)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 8'd1;
      // the counter parks at SC so a long dwell strobes once
      strobe = (cnt_d == SC) && (chg || cnt_q != SC);
      blank  = en_q == 4'hF;
      cap    = strobe && legal;
      eerr   = strobe && !legal && !blank;
      tmo    = !cap && (to_q >= TLAST);
      frame  = mask_q == 4'hF;

      if (cap)
         to_d = '0;
      else if (to_q == TMAX)
         to_d = to_q;
      else
         to_d = to_q + TW'(1);

      mask_d  = (frame || eerr || tmo) ? 4'h0 : mask_q;
      shv_d   = shv_q;
      shdp_d  = shdp_q;
      sherr_d = sherr_q;
      if (cap) begin
         mask_d[idx]  = 1'b1;
         shv_d[idx]   = val;
         shdp_d[idx]  = ~seg_q[7];
         sherr_d[idx] = gerr;
      end
   end

   // input stage resets to a blanked bus so it never
   // looks like an illegal enable after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_q      <= 8'hFF;
         en_q       <= 4'hF;
         seg_last_q <= 8'hFF;
         en_last_q  <= 4'hF;
         cnt_q      <= '0;
         to_q       <= '0;
         mask_q     <= '0;
         shv_q      <= '0;
         shdp_q     <= '0;
         sherr_q    <= '0;
         num_q      <= '0;
         dp_q       <= '0;
         derr_q     <= '0;
         fv_q       <= 1'b0;
         ee_q       <= 1'b0;
      end else begin
         seg_q      <= bus.sev_seg_leds;
         en_q       <= bus.led_enable;
         seg_last_q <= seg_q;
         en_last_q  <= en_q;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         mask_q     <= mask_d;
         shv_q      <= shv_d;
         shdp_q     <= shdp_d;
         sherr_q    <= sherr_d;
         fv_q       <= frame;
         ee_q       <= eerr;
         if (frame) begin
            num_q  <= shv_q;
            dp_q   <= shdp_q;
            derr_q <= sherr_q;
         end
      end
   end

   assign bus.num_1       = num_q[0];
   assign bus.num_2       = num_q[1];
   assign bus.num_3       = num_q[2];
   assign bus.num_4       = num_q[3];
   assign bus.dp          = dp_q;
   assign bus.digit_err   = derr_q;
   assign bus.frame_valid = fv_q;
   assign bus.enable_err  = ee_q;
endmodule

// File: tb/tb_sev_seg_capture.sv
// Bench for sev_seg_capture: two instances (dwell 1 and 3)
// driven in lockstep and checked against a sequence model.
module tb_sev_seg_capture;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sev_seg_capture_if b1 ();
   sev_seg_capture_if b3 ();

   sev_seg_capture #(
      .STABLE_CYCLES(1),
      .TIMEOUT(TMO)
   ) u1 (
      .clk(clk),
      .reset(reset),
      .bus(b1.slave)
   );

   sev_seg_capture #(
      .STABLE_CYCLES(3),
      .TIMEOUT(TMO)
   ) u3 (
      .clk(clk),
      .reset(reset),
      .bus(b3.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  glyph [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };
   logic [3:0]  bad_en [8] = '{
      4'h0, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h1
   };

   // each entry is {enable, segments} for one clock
   logic [11:0] seq [$];
   logic [25:0] exq [$];
   logic [25:0] exp1 [$];
   logic [25:0] exp3 [$];

   function automatic logic [25:0] obs1();
      return {b1.num_4, b1.num_3, b1.num_2, b1.num_1,
              b1.dp, b1.digit_err,
              b1.frame_valid, b1.enable_err};
   endfunction

   function automatic logic [25:0] obs3();
      return {b3.num_4, b3.num_3, b3.num_2, b3.num_1,
              b3.dp, b3.digit_err,
              b3.frame_valid, b3.enable_err};
   endfunction

   task automatic drive(input logic [11:0] p);
      b1.led_enable   = p[11:8];
      b1.sev_seg_leds = p[7:0];
      b3.led_enable   = p[11:8];
      b3.sev_seg_leds = p[7:0];
   endtask

   task automatic push(input logic [3:0] en,
                       input logic [7:0] sg,
                       input int n);
      repeat (n) seq.push_back({en, sg});
   endtask

   function automatic logic [3:0] den(input int d);
      logic [3:0] e;
      e = 4'b0001 << d;
      return ~e;
   endfunction

   task automatic dec(input logic [7:0] s,
                      output logic [3:0] v,
                      output logic e);
      v = 4'h0;
      e = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (s[6:0] == glyph[i][6:0]) begin
            v = 4'(i);
            e = 1'b0;
         end
      end
   endtask

   // expected outputs after each edge, from dwell lengths
   task automatic model(input int S);
      logic [11:0] s [$];
      int          r [$];
      logic [3:0]  mask, shdp, sherr, odp, oerr, en, v;
      logic [3:0]  shv [4];
      logic [3:0]  onum [4];
      logic        pend, fv, ee, er;
      int          lastcap, k;
      bit          st;
      s.push_back(12'hFFF);
      foreach (seq[i]) s.push_back(seq[i]);
      r.push_back(1);
      for (int i = 1; i < s.size(); i++)
         r.push_back(s[i] == s[i-1] ? r[i-1] + 1 : 1);
      mask = 0; shdp = 0; sherr = 0; odp = 0; oerr = 0;
      for (int i = 0; i < 4; i++) begin
         shv[i] = 0;
         onum[i] = 0;
      end
      pend = 0;
      lastcap = 0;
      exq.delete();
      for (int e = 1; e < s.size(); e++) begin
         fv = 0;
         ee = 0;
         if (pend) begin
            onum = shv;
            odp  = shdp;
            oerr = sherr;
            fv   = 1;
            mask = 0;
            pend = 0;
         end
         st = (r[e-1] == S);
         en = s[e-1][11:8];
         k  = -1;
         for (int d = 0; d < 4; d++)
            if (en == den(d)) k = d;
         if (st && k >= 0) begin
            lastcap = e;
            dec(s[e-1][7:0], v, er);
            shv[k]   = v;
            sherr[k] = er;
            shdp[k]  = ~s[e-1][7];
            mask[k]  = 1'b1;
         end else begin
            if (st && en != 4'hF) begin
               ee   = 1;
               mask = 0;
            end
            if (e - lastcap >= TMO) mask = 0;
         end
         if (mask == 4'hF) pend = 1;
         exq.push_back({onum[3], onum[2], onum[1], onum[0],
                        odp, oerr, fv, ee});
      end
   endtask

   task automatic run_seq(input string name);
      logic [25:0] o;
      model(1);
      exp1 = exq;
      model(3);
      exp3 = exq;
      @(negedge clk);
      reset = 1'b0;
      drive(12'hFFF);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int e = 0; e < seq.size(); e++) begin
         drive(seq[e]);
         @(posedge clk);
         #1;
         o = obs1();
         n_chk++;
         if (o !== exp1[e]) begin
            n_fail++;
            $display("FAIL %s s1 edge %0d: got %h want %h",
                     name, e + 1, o, exp1[e]);
         end
         o = obs3();
         n_chk++;
         if (o !== exp3[e]) begin
            n_fail++;
            $display("FAIL %s s3 edge %0d: got %h want %h",
                     name, e + 1, o, exp3[e]);
         end
         @(negedge clk);
      end
      seq.delete();
   endtask

   task automatic scan(input int n, input int d0);
      for (int d = 0; d < 4; d++)
         push(den(d), glyph[(d + d0) % 16], n);
   endtask

   task automatic test_basic();
      push(4'hF, 8'hFF, 2);
      scan(1, 1);
      push(4'hF, 8'hFF, 4);
      scan(3, 1);
      push(4'hF, 8'hFF, 4);
      run_seq("basic");
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_chk++;
      if (obs1() !== 26'h0) begin
         n_fail++;
         $display("FAIL reset s1: got %h want 0", obs1());
      end
      n_chk++;
      if (obs3() !== 26'h0) begin
         n_fail++;
         $display("FAIL reset s3: got %h want 0", obs3());
      end
   endtask

   task automatic test_bad_glyph();
      push(4'hF, 8'hFF, 2);
      push(den(0), 8'hF9, 3);
      push(den(1), 8'hFF, 3);
      push(den(2), 8'h30, 3);
      push(den(3), 8'h99, 3);
      push(4'hF, 8'hFF, 4);
      run_seq("bad_glyph");
   endtask

   task automatic test_enable_err();
      push(4'hF, 8'hFF, 2);
      push(4'hE, 8'hF9, 3);
      push(4'hC, 8'hA4, 3);
      scan(3, 1);
      push(4'hF, 8'hFF, 4);
      run_seq("enable_err");
   endtask

   task automatic test_glitch();
      push(4'hF, 8'hFF, 2);
      push(den(0), 8'hF9, 2);
      push(den(1), 8'h88, 1);
      push(den(0), 8'hF9, 4);
      push(den(1), 8'hA4, 4);
      push(den(2), 8'hB0, 4);
      push(den(3), 8'h99, 4);
      push(4'hF, 8'hFF, 4);
      run_seq("glitch");
   endtask

   task automatic test_timeout();
      push(4'hF, 8'hFF, 2);
      push(den(0), 8'hF9, 3);
      push(den(1), 8'hA4, 3);
      push(den(2), 8'hB0, 3);
      push(4'hF, 8'hFF, TMO + 4);
      push(den(3), 8'h99, 3);
      push(4'hF, 8'hFF, 6);
      scan(3, 5);
      push(4'hF, 8'hFF, 4);
      run_seq("timeout");
   endtask

   task automatic test_reset_midframe();
      push(4'hF, 8'hFF, 2);
      scan(3, 5);
      push(4'hF, 8'hFF, 2);
      push(den(0), 8'hF9, 3);
      push(den(1), 8'hA4, 3);
      push(den(2), 8'hB0, 3);
      run_seq("pre_reset");
      push(4'hF, 8'hFF, 2);
      push(den(3), 8'h99, 3);
      push(4'hF, 8'hFF, 6);
      scan(3, 9);
      push(4'hF, 8'hFF, 4);
      run_seq("post_reset");
   endtask

   task automatic test_back_to_back();
      push(4'hF, 8'hFF, 2);
      scan(1, 2);
      scan(1, 6);
      scan(3, 10);
      scan(3, 14);
      push(4'hF, 8'hFF, 4);
      run_seq("back_to_back");
   endtask

   task automatic test_random();
      int   sel;
      logic [7:0] sg;
      for (int it = 0; it < 8; it++) begin
         push(4'hF, 8'hFF, 2);
         repeat ($urandom_range(8, 16)) begin
            sel = $urandom_range(0, 19);
            if (sel < 16) begin
               if ($urandom_range(0, 7) == 0)
                  sg = 8'($urandom);
               else
                  sg = glyph[$urandom_range(0, 15)];
               if ($urandom_range(0, 1) == 1) sg[7] = 1'b0;
               push(den($urandom_range(0, 3)), sg,
                    $urandom_range(1, 4));
            end else if (sel < 19) begin
               push(4'hF, 8'hFF, $urandom_range(1, 3));
            end else begin
               push(bad_en[$urandom_range(0, 7)],
                    glyph[$urandom_range(0, 15)],
                    $urandom_range(1, 4));
            end
         end
         push(4'hF, 8'hFF, 4);
         run_seq("random");
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(12'hFFF);
      repeat (2) @(negedge clk);
      test_basic();
      test_reset();
      test_bad_glyph();
      test_enable_err();
      test_glitch();
      test_timeout();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
